// File: rtl/ex_stage_pkg.sv
// Shared EX/ID definitions: bus widths, operation class and subop codes.
// Also provides the GPR-write decode used by the EX stage control.
package ex_stage_pkg;

  localparam int unsigned EX_OP_W    = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [EX_OP_W-1:0]    ex_op_bus_t;
  typedef logic [WORD_W-1:0]     word_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

  localparam reg_addr_bus_t REG_ZERO = '0;

  typedef enum logic [3:0] {
    CLS_SPECIAL = 4'h0,
    CLS_LOGIC   = 4'h1
  } ex_class_e;

  typedef enum logic [3:0] {
    SUB_AND    = 4'h0,
    SUB_OR     = 4'h1,
    SUB_XOR    = 4'h2,
    SUB_NOR    = 4'h3,
    SUB_SLL    = 4'h4,
    SUB_SRL    = 4'h5,
    SUB_SRA    = 4'h6,
    SUB_LUI    = 4'h7,
    SUB_FROMHI = 4'h8,
    SUB_FROMLO = 4'h9,
    SUB_TOHI   = 4'hA,
    SUB_TOLO   = 4'hB
  } ex_subop_e;

  localparam logic [3:0] SUB_NOP = 4'h0;

  // Every defined LOGIC subop up to FROMLO produces a GPR result.
  function automatic logic writes_gpr(input ex_op_bus_t op);
    return (op[7:4] == CLS_LOGIC) && (op[3:0] <= SUB_FROMLO);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Purely combinational EX datapath: logic, shifts, LUI and HI/LO moves.
// Undefined classes or subops yield a zero result with no side effects.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [EX_OP_W-1:0] i_exop,
  input  logic [WORD_W-1:0]  i_left,
  input  logic [WORD_W-1:0]  i_right,
  input  logic [WORD_W-1:0]  i_hi,
  input  logic [WORD_W-1:0]  i_lo,
  output logic [WORD_W-1:0]  o_result,
  output logic               o_writes_gpr,
  output logic               o_hi_we,
  output logic               o_lo_we
);

  logic [4:0] w_shamt;

  assign w_shamt      = i_left[4:0];
  assign o_writes_gpr = writes_gpr(i_exop);

  always_comb begin
    o_result = '0;
    o_hi_we  = 1'b0;
    o_lo_we  = 1'b0;
    if (i_exop[7:4] == CLS_LOGIC) begin
      case (i_exop[3:0])
        SUB_AND:    o_result = i_left & i_right;
        SUB_OR:     o_result = i_left | i_right;
        SUB_XOR:    o_result = i_left ^ i_right;
        SUB_NOR:    o_result = ~(i_left | i_right);
        SUB_SLL:    o_result = i_right << w_shamt;
        SUB_SRL:    o_result = i_right >> w_shamt;
        SUB_SRA:    o_result = word_bus_t'($signed(i_right) >>> w_shamt);
        SUB_LUI:    o_result = {i_right[15:0], 16'h0000};
        SUB_FROMHI: o_result = i_hi;
        SUB_FROMLO: o_result = i_lo;
        SUB_TOHI:   o_hi_we  = 1'b1;
        SUB_TOLO:   o_lo_we  = 1'b1;
        default:    o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: registers the ALU result with one-cycle latency and owns HI/LO.
// Flush beats stall; a stalled stage holds every register including HI/LO.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [EX_OP_W-1:0]    i_exop,
  input  logic [WORD_W-1:0]     i_srcLeft,
  input  logic [WORD_W-1:0]     i_srcRight,
  input  logic [REG_ADDR_W-1:0] i_dest,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic                  o_writeEnable,
  output logic [REG_ADDR_W-1:0] o_dest,
  output logic [WORD_W-1:0]     o_result,
  output logic [WORD_W-1:0]     o_hi,
  output logic [WORD_W-1:0]     o_lo
);

  logic                  r_valid;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [WORD_W-1:0]     r_result;
  logic [WORD_W-1:0]     r_hi;
  logic [WORD_W-1:0]     r_lo;

  logic [WORD_W-1:0]     w_result;
  logic                  w_writes_gpr;
  logic                  w_hi_we;
  logic                  w_lo_we;
  logic                  w_accept;

  ex_alu u_alu (
    .i_exop       (i_exop),
    .i_left       (i_srcLeft),
    .i_right      (i_srcRight),
    .i_hi         (r_hi),
    .i_lo         (r_lo),
    .o_result     (w_result),
    .o_writes_gpr (w_writes_gpr),
    .o_hi_we      (w_hi_we),
    .o_lo_we      (w_lo_we)
  );

  // A real instruction that is neither stalled nor flushed this edge.
  assign w_accept = i_valid && !i_stall && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_dest   <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (i_flush) begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_dest   <= '0;
      r_result <= '0;
    end else if (!i_stall) begin
      r_valid  <= i_valid;
      r_we     <= i_valid && w_writes_gpr && (i_dest != REG_ZERO);
      r_dest   <= i_dest;
      r_result <= w_result;
      if (w_accept && w_hi_we) r_hi <= i_srcLeft;
      if (w_accept && w_lo_we) r_lo <= i_srcLeft;
    end
  end

  assign o_valid       = r_valid;
  assign o_writeEnable = r_we;
  assign o_dest        = r_dest;
  assign o_result      = r_result;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_exop;
  logic [31:0] i_srcLeft;
  logic [31:0] i_srcRight;
  logic [4:0]  i_dest;
  logic        i_stall;
  logic        i_flush;
  logic        o_valid;
  logic        o_writeEnable;
  logic [4:0]  o_dest;
  logic [31:0] o_result;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_tests;
  int n_fail;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_exop        (i_exop),
    .i_srcLeft     (i_srcLeft),
    .i_srcRight    (i_srcRight),
    .i_dest        (i_dest),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .o_writeEnable (o_writeEnable),
    .o_dest        (o_dest),
    .o_result      (o_result),
    .o_hi          (o_hi),
    .o_lo          (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 time unit past the edge.
  task automatic apply(input logic v, input logic [7:0] op, input logic [31:0] l,
                       input logic [31:0] r, input logic [4:0] d,
                       input logic st, input logic fl);
    i_valid    = v;
    i_exop     = op;
    i_srcLeft  = l;
    i_srcRight = r;
    i_dest     = d;
    i_stall    = st;
    i_flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_exop     = 8'h00;
    i_srcLeft  = '0;
    i_srcRight = '0;
    i_dest     = '0;
    i_stall    = 1'b0;
    i_flush    = 1'b0;

    #2;
    check("rst_valid",  {31'b0, o_valid}, 32'h0);
    check("rst_we",     {31'b0, o_writeEnable}, 32'h0);
    check("rst_dest",   {27'b0, o_dest}, 32'h0);
    check("rst_result", o_result, 32'h0);
    check("rst_hi",     o_hi, 32'h0);
    check("rst_lo",     o_lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ORI
    apply(1, 8'h11, 32'h0000_1200, 32'h0000_0034, 5'd5, 0, 0);
    check("ori_result", o_result, 32'h0000_1234);
    check("ori_we",     {31'b0, o_writeEnable}, 32'h1);
    check("ori_dest",   {27'b0, o_dest}, 32'd5);
    check("ori_valid",  {31'b0, o_valid}, 32'h1);

    // Shifts and remaining logic ops
    apply(1, 8'h16, 32'd4, 32'h8000_0000, 5'd7, 0, 0);
    check("sra_result", o_result, 32'hF800_0000);
    apply(1, 8'h15, 32'd4, 32'h8000_0000, 5'd7, 0, 0);
    check("srl_result", o_result, 32'h0800_0000);
    apply(1, 8'h14, 32'd4, 32'h0000_00F1, 5'd7, 0, 0);
    check("sll_result", o_result, 32'h0000_0F10);
    apply(1, 8'h12, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd8, 0, 0);
    check("xor_result", o_result, 32'h5A5A_A5A5);
    apply(1, 8'h13, 32'h0000_0000, 32'h0F0F_0F0F, 5'd8, 0, 0);
    check("nor_result", o_result, 32'hF0F0_F0F0);
    apply(1, 8'h17, 32'h0, 32'h1234_ABCD, 5'd8, 0, 0);
    check("lui_result", o_result, 32'hABCD_0000);

    // TOHI then FROMHI back-to-back
    apply(1, 8'h1A, 32'hDEAD_BEEF, 32'h0, 5'd4, 0, 0);
    check("tohi_we",    {31'b0, o_writeEnable}, 32'h0);
    check("tohi_hi",    o_hi, 32'hDEAD_BEEF);
    apply(1, 8'h18, 32'h0, 32'h0, 5'd3, 0, 0);
    check("fromhi_result", o_result, 32'hDEAD_BEEF);
    check("fromhi_we",     {31'b0, o_writeEnable}, 32'h1);

    // TOLO then FROMLO
    apply(1, 8'h1B, 32'h5555_AAAA, 32'h0, 5'd4, 0, 0);
    check("tolo_lo", o_lo, 32'h5555_AAAA);
    apply(1, 8'h19, 32'h0, 32'h0, 5'd6, 0, 0);
    check("fromlo_result", o_result, 32'h5555_AAAA);

    // Stall then stall+flush
    apply(1, 8'h10, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9, 0, 0);
    check("and_result", o_result, 32'hF000_F000);
    for (int i = 0; i < 3; i++) begin
      apply(1, 8'h1A, 32'h1111_1111, 32'h2222_2222, 5'd2, 1, 0);
      check("stall_result", o_result, 32'hF000_F000);
      check("stall_dest",   {27'b0, o_dest}, 32'd9);
      check("stall_hi",     o_hi, 32'hDEAD_BEEF);
    end
    apply(1, 8'h1A, 32'h1111_1111, 32'h2222_2222, 5'd2, 1, 1);
    check("flush_valid",  {31'b0, o_valid}, 32'h0);
    check("flush_we",     {31'b0, o_writeEnable}, 32'h0);
    check("flush_result", o_result, 32'h0);
    check("flush_dest",   {27'b0, o_dest}, 32'h0);
    check("flush_hi",     o_hi, 32'hDEAD_BEEF);

    // Bubble carrying a TOHI must not write HI
    apply(0, 8'h1A, 32'h3333_3333, 32'h0, 5'd2, 0, 0);
    check("bubble_valid", {31'b0, o_valid}, 32'h0);
    check("bubble_hi",    o_hi, 32'hDEAD_BEEF);

    // Dest 0 and undefined ops
    apply(1, 8'h11, 32'h1, 32'h2, 5'd0, 0, 0);
    check("dest0_we",    {31'b0, o_writeEnable}, 32'h0);
    check("dest0_valid", {31'b0, o_valid}, 32'h1);
    apply(1, 8'h2F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, 0);
    check("undef_result", o_result, 32'h0);
    check("undef_we",     {31'b0, o_writeEnable}, 32'h0);
    check("undef_hi",     o_hi, 32'hDEAD_BEEF);
    check("undef_lo",     o_lo, 32'h5555_AAAA);
    apply(1, 8'h1C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, 0);
    check("undef_sub_result", o_result, 32'h0);
    check("undef_sub_we",     {31'b0, o_writeEnable}, 32'h0);

    // Async reset mid-cycle after TOLO
    apply(1, 8'h1B, 32'h0000_1234, 32'h0, 5'd1, 0, 0);
    check("tolo2_lo", o_lo, 32'h0000_1234);
    #2 rst = 1'b1;
    #1;
    check("arst_lo",    o_lo, 32'h0);
    check("arst_hi",    o_hi, 32'h0);
    check("arst_valid", {31'b0, o_valid}, 32'h0);
    #2 rst = 1'b0;

    // First edge after reset accepts input
    apply(1, 8'h11, 32'h0000_1200, 32'h0000_0034, 5'd5, 0, 0);
    check("post_rst_result", o_result, 32'h0000_1234);
    check("post_rst_we",     {31'b0, o_writeEnable}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
